// File: rtl/spi_master.sv
// spi_master: SPI mode-0 (CPOL=0, CPHA=0) initiator. One DATA_W-bit full-duplex
// frame per accepted request: SETUP -> SHIFT -> HOLD -> GAP, each phase timed
// in units of the half-period H = BASE_HALF << freq_control, latched at start.
module spi_master #(
  parameter int BASE_HALF = 2,
  parameter int DATA_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        freq_control,
  input  logic              tx_start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              miso,
  output logic              sclk,
  output logic              cs_bar,
  output logic              mosi,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_ready,
  output logic              busy
);

  // Half-period counter must hold values up to (BASE_HALF << 3) - 1.
  localparam int HW = $clog2((BASE_HALF << 3) + 1);
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  state_t            r_state;
  logic [HW-1:0]     r_half_cnt;
  logic [HW-1:0]     r_half;
  logic [BW-1:0]     r_bit_cnt;
  logic [DATA_W-1:0] r_tx_sh;
  logic [DATA_W-1:0] r_rx_sh;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_sclk;
  logic              r_cs_bar;
  logic              r_mosi;
  logic              r_rx_valid;
  logic              r_busy;
  logic              r_tx_ready;

  logic [HW-1:0]     w_half_sel;
  logic              w_half_end;

  // Requested half-period; only sampled when a frame is accepted.
  assign w_half_sel = HW'(BASE_HALF) << freq_control;
  // Last clk cycle of the current half-period.
  assign w_half_end = (r_half_cnt == (r_half - HW'(1)));

  assign sclk     = r_sclk;
  assign cs_bar   = r_cs_bar;
  assign mosi     = r_mosi;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign tx_ready = r_tx_ready;
  assign busy     = r_busy;

  // Frame sequencer: phase timing, serial shifting and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_half_cnt <= '0;
      r_half     <= '0;
      r_bit_cnt  <= '0;
      r_tx_sh    <= '0;
      r_rx_sh    <= '0;
      r_rx_data  <= '0;
      r_sclk     <= 1'b0;
      r_cs_bar   <= 1'b1;
      r_mosi     <= 1'b0;
      r_rx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_tx_ready <= 1'b1;
    end else begin
      r_rx_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_half_cnt <= '0;
          if (tx_start) begin
            // MSB goes straight onto mosi; the rest waits in the shifter.
            r_state    <= ST_SETUP;
            r_half     <= w_half_sel;
            r_bit_cnt  <= '0;
            r_mosi     <= tx_data[DATA_W-1];
            r_tx_sh    <= {tx_data[DATA_W-2:0], 1'b0};
            r_rx_sh    <= '0;
            r_cs_bar   <= 1'b0;
            r_busy     <= 1'b1;
            r_tx_ready <= 1'b0;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          if (w_half_end) begin
            // First rising sclk edge; miso is sampled on the same clk edge.
            r_half_cnt <= '0;
            r_sclk     <= 1'b1;
            r_rx_sh    <= {r_rx_sh[DATA_W-2:0], miso};
            r_state    <= ST_SHIFT;
          end else begin
            r_half_cnt <= r_half_cnt + HW'(1);
          end
        end
        ST_SHIFT: begin
          if (w_half_end) begin
            r_half_cnt <= '0;
            if (r_sclk) begin
              r_sclk <= 1'b0;
              if (r_bit_cnt == BW'(DATA_W - 1)) begin
                // Last bit stays on mosi through HOLD.
                r_state <= ST_HOLD;
              end else begin
                r_bit_cnt <= r_bit_cnt + BW'(1);
                r_mosi    <= r_tx_sh[DATA_W-1];
                r_tx_sh   <= {r_tx_sh[DATA_W-2:0], 1'b0};
              end
            end else begin
              r_sclk  <= 1'b1;
              r_rx_sh <= {r_rx_sh[DATA_W-2:0], miso};
            end
          end else begin
            r_half_cnt <= r_half_cnt + HW'(1);
          end
        end
        ST_HOLD: begin
          if (w_half_end) begin
            r_half_cnt <= '0;
            r_cs_bar   <= 1'b1;
            r_mosi     <= 1'b0;
            r_rx_data  <= r_rx_sh;
            r_rx_valid <= 1'b1;
            r_state    <= ST_GAP;
          end else begin
            r_half_cnt <= r_half_cnt + HW'(1);
          end
        end
        ST_GAP: begin
          if (w_half_end) begin
            r_half_cnt <= '0;
            r_busy     <= 1'b0;
            r_tx_ready <= 1'b1;
            r_state    <= ST_IDLE;
          end else begin
            r_half_cnt <= r_half_cnt + HW'(1);
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_half_cnt <= '0;
          r_sclk     <= 1'b0;
          r_cs_bar   <= 1'b1;
          r_mosi     <= 1'b0;
          r_busy     <= 1'b0;
          r_tx_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: randomized and directed stimulus for spi_master, checked every
// cycle against a timing model expressed as offsets from the acceptance cycle,
// with a behavioural mode-0 slave on miso.
module tb_spi_master;

  localparam int BASE_HALF = 2;
  localparam int DATA_W    = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] freq_control;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       miso;
  logic       sclk, cs_bar, mosi;
  logic [7:0] rx_data;
  logic       rx_valid, tx_ready, busy;

  spi_master #(.BASE_HALF(BASE_HALF), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .freq_control(freq_control), .tx_start(tx_start),
    .tx_data(tx_data), .miso(miso), .sclk(sclk), .cs_bar(cs_bar), .mosi(mosi),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_ready(tx_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Frame model: one frame in flight, described by its acceptance cycle.
  bit         m_active = 1'b0;
  int         m_t = 0;
  int         m_h = 1;
  logic [7:0] m_tx = 8'h00;
  logic [7:0] m_rx = 8'h00;
  logic [7:0] m_rxd = 8'h00;

  // Observations of DUT behaviour used by the directed checks.
  int   valid_cnt = 0, valid_cyc = 0, cs_fall_cnt = 0, cs_fall_cyc = 0;
  int   cs_rise_cyc = 0, ready_cyc = 0, hi_run = 0, last_hi = 0;
  logic prev_cs = 1'b1, prev_ready = 1'b1;

  // Behavioural slave and mosi capture.
  logic [7:0] slave_byte;
  logic [7:0] sl_sh = 8'h00;
  bit         sl_loaded = 1'b0;
  logic [7:0] mosi_cap = 8'h00;
  int         rise_cnt = 0;

  // Mode-0 slave: MSB ready when selected, next bit after each sclk fall.
  always @(cs_bar or negedge sclk) begin
    if (cs_bar !== 1'b0) begin
      miso      = 1'b0;
      sl_loaded = 1'b0;
    end else if (!sl_loaded) begin
      sl_sh     = slave_byte;
      miso      = sl_sh[7];
      sl_loaded = 1'b1;
    end else if (!sclk) begin
      sl_sh = {sl_sh[6:0], 1'b0};
      miso  = sl_sh[7];
    end
  end

  // Record mosi at each sclk rise; restart at every new chip select.
  always @(posedge sclk or negedge cs_bar) begin
    if (sclk) begin
      mosi_cap = {mosi_cap[6:0], mosi};
      rise_cnt = rise_cnt + 1;
    end else begin
      mosi_cap = 8'h00;
      rise_cnt = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_check();
    int   n, q, b;
    logic e_cs, e_sclk, e_mosi, e_valid, e_busy, e_ready;
    n = 0;
    e_cs = 1'b1; e_sclk = 1'b0; e_mosi = 1'b0; e_valid = 1'b0; e_busy = 1'b0; e_ready = 1'b1;
    if (reset !== 1'b1) begin
      m_active = 1'b0;
      m_rxd    = 8'h00;
    end else begin
      if (m_active) begin
        n = cyc - m_t;
        if (n > 18 * m_h) m_active = 1'b0;
      end
      if (m_active) begin
        q = (n - 1) / m_h;
        b = (n - 1) / (2 * m_h);
        if (b > 7) b = 7;
        e_cs    = (n <= 17 * m_h) ? 1'b0 : 1'b1;
        e_sclk  = (n <= 16 * m_h) && (q % 2 == 1);
        e_mosi  = (n <= 17 * m_h) ? m_tx[7 - b] : 1'b0;
        e_valid = (n == 17 * m_h + 1);
        e_busy  = 1'b1;
        e_ready = 1'b0;
        if (e_valid) m_rxd = m_rx;
      end
    end
    chk("cs_bar",   32'(cs_bar),   32'(e_cs));
    chk("sclk",     32'(sclk),     32'(e_sclk));
    chk("mosi",     32'(mosi),     32'(e_mosi));
    chk("rx_valid", 32'(rx_valid), 32'(e_valid));
    chk("busy",     32'(busy),     32'(e_busy));
    chk("tx_ready", 32'(tx_ready), 32'(e_ready));
    chk("rx_data",  32'(rx_data),  32'(m_rxd));
    if (rx_valid === 1'b1) begin valid_cnt = valid_cnt + 1; valid_cyc = cyc; end
    if (cs_bar === 1'b0 && prev_cs === 1'b1) begin cs_fall_cnt = cs_fall_cnt + 1; cs_fall_cyc = cyc; end
    if (cs_bar === 1'b1 && prev_cs === 1'b0) cs_rise_cyc = cyc;
    if (tx_ready === 1'b1 && prev_ready === 1'b0) ready_cyc = cyc;
    prev_cs    = cs_bar;
    prev_ready = tx_ready;
    if (sclk === 1'b1) hi_run = hi_run + 1;
    else begin
      if (hi_run > 0) last_hi = hi_run;
      hi_run = 0;
    end
    // Acceptance decision for the coming rising edge.
    if (reset === 1'b1 && !m_active && tx_start === 1'b1) begin
      m_active = 1'b1;
      m_t      = cyc;
      m_h      = BASE_HALF << freq_control;
      m_tx     = tx_data;
      m_rx     = slave_byte;
    end
  endtask

  // One clk cycle: check at the falling edge, return 1 time unit after the rise.
  task automatic step();
    @(negedge clk);
    model_check();
    @(posedge clk);
    cyc = cyc + 1;
    #1;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (m_active && k < 400) begin
      step();
      k = k + 1;
    end
    checks = checks + 1;
    if (m_active) begin
      errors = errors + 1;
      $display("FAIL %s: frame still active after %0d cycles, required idle", name, k);
    end
  endtask

  task automatic start_frame(input logic [7:0] d, input logic [1:0] fc, input logic [7:0] s);
    tx_data      = d;
    freq_control = fc;
    slave_byte   = s;
    tx_start     = 1'b1;
    step();
    tx_start     = 1'b0;
  endtask

  initial begin
    int t0, v0, f0, k;
    reset = 1'b1; tx_start = 1'b0; tx_data = 8'h00; freq_control = 2'd0; slave_byte = 8'h00;
    #2 reset = 1'b0;
    tx_start = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("rst_cs_bar",   32'(cs_bar),   32'd1);
    chk("rst_sclk",     32'(sclk),     32'd0);
    chk("rst_mosi",     32'(mosi),     32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_rx_data",  32'(rx_data),  32'h00);
    tx_start = 1'b0;
    reset    = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("idle_after_rst_cs", 32'(cs_bar), 32'd1);

    // Single frame at H=2.
    v0 = valid_cnt;
    start_frame(8'hA5, 2'd0, 8'h3C);
    t0 = m_t;
    wait_idle("frame_a5");
    chk("a5_mosi_bits",  32'(mosi_cap),    32'hA5);
    chk("a5_rises",      32'(rise_cnt),    32'd8);
    chk("a5_rx_data",    32'(rx_data),     32'h3C);
    chk("a5_cs_fall",    32'(cs_fall_cyc - t0), 32'd1);
    chk("a5_cs_rise",    32'(cs_rise_cyc - t0), 32'd35);
    chk("a5_valid_time", 32'(valid_cyc - t0),   32'd35);
    chk("a5_ready_time", 32'(ready_cyc - t0),   32'd37);
    chk("a5_valid_cnt",  32'(valid_cnt - v0),   32'd1);

    // Slowest rate, H=16.
    start_frame(8'hFF, 2'd3, 8'h5A);
    t0 = m_t;
    wait_idle("frame_h16");
    chk("h16_valid_time", 32'(valid_cyc - t0), 32'd273);
    chk("h16_rises",      32'(rise_cnt),       32'd8);
    chk("h16_high_len",   32'(last_hi),        32'd16);
    chk("h16_mosi_bits",  32'(mosi_cap),       32'hFF);
    chk("h16_rx_data",    32'(rx_data),        32'h5A);

    // Requests while busy are dropped.
    v0 = valid_cnt; f0 = cs_fall_cnt;
    start_frame(8'h12, 2'd0, 8'hE7);
    for (int i = 0; i < 10; i++) begin
      tx_start = 1'b1; tx_data = 8'h99; freq_control = 2'd2;
      step();
    end
    tx_start = 1'b0;
    wait_idle("frame_ignore");
    for (int i = 0; i < 5; i++) step();
    chk("ign_frames",    32'(cs_fall_cnt - f0), 32'd1);
    chk("ign_valid_cnt", 32'(valid_cnt - v0),   32'd1);
    chk("ign_mosi_bits", 32'(mosi_cap),         32'h12);
    chk("ign_rx_data",   32'(rx_data),          32'hE7);

    // Back-to-back with tx_start held high.
    v0 = valid_cnt; f0 = cs_fall_cnt;
    tx_data = 8'h55; freq_control = 2'd0; slave_byte = 8'h69; tx_start = 1'b1;
    step();
    tx_data = 8'hAA;
    k = 0;
    while (cs_fall_cnt < f0 + 2 && k < 200) begin step(); k = k + 1; end
    tx_start = 1'b0;
    chk("b2b_second_frame", 32'(cs_fall_cnt - f0), 32'd2);
    chk("b2b_deselect",     32'(cs_fall_cyc - cs_rise_cyc), 32'd3);
    wait_idle("frame_b2b");
    chk("b2b_valid_cnt", 32'(valid_cnt - v0), 32'd2);
    chk("b2b_mosi_bits", 32'(mosi_cap),       32'hAA);
    chk("b2b_rx_data",   32'(rx_data),        32'h69);

    // Reset mid-frame after the third sclk rise.
    v0 = valid_cnt;
    start_frame(8'h0F, 2'd1, 8'hB2);
    k = 0;
    while (rise_cnt < 3 && k < 200) begin step(); k = k + 1; end
    chk("abort_rises", 32'(rise_cnt), 32'd3);
    #2 reset = 1'b0;
    #1;
    chk("abort_cs_bar", 32'(cs_bar), 32'd1);
    chk("abort_sclk",   32'(sclk),   32'd0);
    chk("abort_busy",   32'(busy),   32'd0);
    for (int i = 0; i < 4; i++) step();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) step();
    chk("abort_no_valid", 32'(valid_cnt - v0), 32'd0);
    start_frame(8'hC3, 2'd0, 8'h4D);
    wait_idle("frame_c3");
    chk("c3_mosi_bits", 32'(mosi_cap), 32'hC3);
    chk("c3_rx_data",   32'(rx_data),  32'h4D);

    // Randomized frames with noise on the inputs while busy.
    for (int i = 0; i < 25; i++) begin
      start_frame(8'($urandom), 2'($urandom_range(0, 3)), 8'($urandom));
      k = $urandom_range(0, 10);
      for (int j = 0; j < k; j++) begin
        tx_start     = 1'($urandom_range(0, 1));
        tx_data      = 8'($urandom);
        freq_control = 2'($urandom_range(0, 3));
        step();
      end
      tx_start = 1'b0;
      wait_idle("frame_rand");
      k = $urandom_range(0, 3);
      for (int j = 0; j < k; j++) step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- SPI mode-0 (CPOL=0, CPHA=0) master that initiates one 8-bit full-duplex transfer per request: drives cs_bar, sclk and mosi, and samples miso.
- This is the initiator counterpart to the team's spi_slave. It is used on-chip as a loopback or verification partner for spi_slave, and as a master toward external SPI peripherals.
- sclk is derived from clk by a half-period counter. freq_control selects the rate, as in the UART path.

Parameters:
- BASE_HALF, 2, minimum sclk half-period in clk cycles (must be >= 1).
- DATA_W, 8, bits per frame; MSB first.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- freq_control  input  2  sclk rate select; half-period H = BASE_HALF << freq_control (2,4,8,16 cycles at default).
- tx_start  input  1  transfer request; accepted only when tx_ready=1.
- tx_data  input  DATA_W  byte to send; captured on acceptance.
- miso  input  1  serial data from slave.
- sclk  output  1  SPI clock, idle low.
- cs_bar  output  1  chip select, active low.
- mosi  output  1  serial data to slave.
- rx_data  output  DATA_W  last received byte; held until next rx_valid.
- rx_valid  output  1  one-cycle pulse, rx_data updated.
- tx_ready  output  1  high in IDLE; master can accept tx_start.
- busy  output  1  high from the cycle after acceptance until return to IDLE.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, sclk=0, cs_bar=1, mosi=0, rx_data=0, rx_valid=0, busy=0, tx_ready=1, all counters and shift registers 0. Reset mid-frame aborts immediately. No rx_valid is produced for the aborted frame.
- Acceptance: tx_start=1 and tx_ready=1 at edge T. The master latches tx_data into the shift register and latches H from freq_control. Later changes to tx_data or freq_control do not affect the frame in flight. tx_start while busy is ignored, with no queuing.
- State machine: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
- SETUP (from T+1):
  - cs_bar=0, mosi=tx_data[7], busy=1, tx_ready=0.
  - Waits H cycles, then enters SHIFT.
- SHIFT, bit k=1..8:
  - sclk rises at T+1+(2k-1)H. On that same clk edge, miso is shifted into the rx shift register LSB, MSB first.
  - sclk falls at T+1+2kH.
  - On falling edges k=1..7, mosi advances to the next bit.
  - After the falling edge at k=8, go to HOLD. mosi holds the last bit.
- HOLD: cs_bar stays 0 for H cycles after the last falling edge.
  - At T+1+17H: cs_bar=1, mosi=0, rx_data<=received byte, rx_valid=1 for exactly one cycle.
  - Enter GAP.
- GAP: cs_bar high for H cycles (minimum deselect time).
  - At T+1+18H: state=IDLE, busy=0, tx_ready=1.
  - tx_start in that cycle starts the next frame (back-to-back rate = 18H+1 cycles/frame).
- sclk is never high while cs_bar=1. Exactly DATA_W rising edges occur per frame.
- Counters:
  - Half-period counter wide enough for BASE_HALF<<3; counts 0..H-1.
  - Bit counter counts 0..DATA_W-1. No wrap beyond the frame.

Test Plan:
- Reset values: hold reset=0, drive tx_start=1 -> sclk=0, cs_bar=1, mosi=0, rx_valid=0, busy=0, tx_ready=1, rx_data=0x00. Release reset -> still idle until the first tx_start edge.
- Single frame, freq_control=0 (H=2): tx_data=0xA5; a behavioural slave returns 0x3C on miso, changing on sclk falling edges.
  - mosi sampled at sclk rises = 1,0,1,0,0,1,0,1.
  - cs_bar low T+1..T+34, rx_valid pulse at T+35, rx_data=0x3C.
  - tx_ready=1 at T+37.
- Rate select: freq_control=3 (H=16), tx_data=0xFF -> sclk high/low exactly 16 cycles each, 8 pulses. rx_valid at T+1+272.
- Ignore while busy: start 0x12, then assert tx_start with tx_data=0x99 mid-frame -> only 0x12 is shifted; no second frame; a single rx_valid.
- Back-to-back: tx_start held high, tx_data=0x55 then 0xAA -> second cs_bar low exactly H+1 cycles after the first cs_bar rise. Both rx_valid pulses are 1 cycle wide.
- Reset mid-frame: assert reset=0 after the 3rd sclk rise -> cs_bar=1 and sclk=0 asynchronously, no rx_valid. After release, a new 0xC3 frame completes correctly.
